// File: rtl/gpio_config_chain.sv
// gpio_config_chain: serially loaded GPIO configuration registers.
// A shift chain collects an N = NUM_CH*WIDTH bit frame. A load with a
// complete frame commits it to gpio_config. A load with a short frame is
// rejected with a load_err pulse. restore_defaults reinstates the
// per-channel defaults. serial_data_out feeds the next block in the chain.
module gpio_config_chain #(
    parameter int NUM_CH   = 4,
    parameter int WIDTH    = 10,
    parameter     DEFAULTS = 40'h01C0701C07
) (
    input  logic                      serial_clock,
    input  logic                      resetn,
    input  logic                      shift_en,
    input  logic                      serial_data_in,
    input  logic                      load,
    input  logic                      restore_defaults,
    output logic                      serial_data_out,
    output logic [NUM_CH*WIDTH-1:0]   gpio_config,
    output logic                      frame_ready,
    output logic                      load_err,
    output logic                      cfg_updated
);

    localparam int N  = NUM_CH * WIDTH;
    localparam int CW = $clog2(N + 1);
    localparam logic [N-1:0]  DEF_C = N'(DEFAULTS);
    localparam logic [CW-1:0] N_CNT = CW'(N);

    // Reject illegal geometries and a default vector of the wrong width.
    if (NUM_CH < 1) begin : g_bad_num_ch
        $error("gpio_config_chain: NUM_CH must be >= 1");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("gpio_config_chain: WIDTH must be >= 1");
    end
    if ($bits(DEFAULTS) != NUM_CH * WIDTH) begin : g_bad_defaults
        $error("gpio_config_chain: DEFAULTS width must equal NUM_CH*WIDTH");
    end

    logic [N-1:0]  shreg_r;
    logic [N-1:0]  cfg_r;
    logic [CW-1:0] bitcnt_r;
    logic          load_err_r;
    logic          cfg_updated_r;

    logic [N-1:0]  shreg_nxt_s;
    logic [N-1:0]  cfg_nxt_s;
    logic [CW-1:0] bitcnt_nxt_s;
    logic          load_err_nxt_s;
    logic          cfg_updated_nxt_s;
    logic [N:0]    shift_cat_s;
    logic          frame_full_s;

    assign frame_full_s    = (bitcnt_r == N_CNT);
    assign shift_cat_s     = {shreg_r, serial_data_in};
    assign frame_ready     = frame_full_s;
    assign serial_data_out = shreg_r[N-1];
    assign gpio_config     = cfg_r;
    assign load_err        = load_err_r;
    assign cfg_updated     = cfg_updated_r;

    // Next-state logic: restore wins; otherwise shift and load act together,
    // with load seeing the pre-shift register contents and count.
    always_comb begin
        shreg_nxt_s       = shreg_r;
        cfg_nxt_s         = cfg_r;
        bitcnt_nxt_s      = bitcnt_r;
        load_err_nxt_s    = 1'b0;
        cfg_updated_nxt_s = 1'b0;
        if (restore_defaults) begin
            shreg_nxt_s       = DEF_C;
            cfg_nxt_s         = DEF_C;
            bitcnt_nxt_s      = {CW{1'b0}};
            cfg_updated_nxt_s = 1'b1;
        end else begin
            if (shift_en) begin
                shreg_nxt_s = shift_cat_s[N-1:0];
                if (frame_full_s) begin
                    bitcnt_nxt_s = N_CNT;
                end else begin
                    bitcnt_nxt_s = bitcnt_r + {{(CW-1){1'b0}}, 1'b1};
                end
            end else begin
                shreg_nxt_s = shreg_r;
            end
            if (load) begin
                if (frame_full_s) begin
                    cfg_nxt_s         = shreg_r;
                    cfg_updated_nxt_s = 1'b1;
                    bitcnt_nxt_s      = shift_en ? {{(CW-1){1'b0}}, 1'b1} : {CW{1'b0}};
                end else begin
                    load_err_nxt_s = 1'b1;
                end
            end else begin
                cfg_nxt_s = cfg_r;
            end
        end
    end

    // State registers; reset puts the defaults live and discards any partial frame.
    always_ff @(posedge serial_clock or negedge resetn) begin
        if (!resetn) begin
            shreg_r       <= DEF_C;
            cfg_r         <= DEF_C;
            bitcnt_r      <= {CW{1'b0}};
            load_err_r    <= 1'b0;
            cfg_updated_r <= 1'b0;
        end else begin
            shreg_r       <= shreg_nxt_s;
            cfg_r         <= cfg_nxt_s;
            bitcnt_r      <= bitcnt_nxt_s;
            load_err_r    <= load_err_nxt_s;
            cfg_updated_r <= cfg_updated_nxt_s;
        end
    end

endmodule

// File: tb/tb_gpio_config_chain.sv
// Self-checking bench for gpio_config_chain (default parameters).
// A bit-history model predicts every output each cycle; literal checks pin
// the key values of each scenario.
module tb_gpio_config_chain;

    localparam int          N   = 40;
    localparam logic [39:0] DEF = 40'h01C0701C07;

    logic        serial_clock = 1'b0;
    logic        resetn;
    logic        shift_en;
    logic        serial_data_in;
    logic        load;
    logic        restore_defaults;
    logic        serial_data_out;
    logic [39:0] gpio_config;
    logic        frame_ready;
    logic        load_err;
    logic        cfg_updated;

    gpio_config_chain dut (
        .serial_clock     (serial_clock),
        .resetn           (resetn),
        .shift_en         (shift_en),
        .serial_data_in   (serial_data_in),
        .load             (load),
        .restore_defaults (restore_defaults),
        .serial_data_out  (serial_data_out),
        .gpio_config      (gpio_config),
        .frame_ready      (frame_ready),
        .load_err         (load_err),
        .cfg_updated      (cfg_updated)
    );

    always #5 serial_clock = ~serial_clock;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Model: the last N bits seen by the chain (oldest first), plus the number
    // of bits shifted since the last frame boundary (unbounded).
    bit          m_hist[$];
    int          m_cnt;
    logic [39:0] m_cfg;
    logic        m_err;
    logic        m_upd;

    function automatic logic [39:0] hist_word();
        logic [39:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[N-1-i] = m_hist[i];
        return v;
    endfunction

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model of the chain behaviour.
    always @(posedge serial_clock or negedge resetn) begin : model
        logic [39:0] pre_word;
        int          pre_cnt;
        if (!resetn) begin
            m_hist.delete();
            for (int i = N - 1; i >= 0; i--) m_hist.push_back(DEF[i]);
            m_cnt = 0;
            m_cfg = DEF;
            m_err = 1'b0;
            m_upd = 1'b0;
        end else begin
            m_err = 1'b0;
            m_upd = 1'b0;
            if (restore_defaults) begin
                m_hist.delete();
                for (int i = N - 1; i >= 0; i--) m_hist.push_back(DEF[i]);
                m_cnt = 0;
                m_cfg = DEF;
                m_upd = 1'b1;
            end else begin
                pre_word = hist_word();
                pre_cnt  = m_cnt;
                if (shift_en) begin
                    m_hist.push_back(serial_data_in);
                    void'(m_hist.pop_front());
                    m_cnt = m_cnt + 1;
                end
                if (load) begin
                    if (pre_cnt >= N) begin
                        m_cfg = pre_word;
                        m_upd = 1'b1;
                        m_cnt = shift_en ? 1 : 0;
                    end else begin
                        m_err = 1'b1;
                    end
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge serial_clock) begin
        if (chk_en) begin
            check("cmp_gpio_config", gpio_config, m_cfg);
            check("cmp_serial_data_out", {39'd0, serial_data_out}, {39'd0, m_hist[0]});
            check("cmp_frame_ready", {39'd0, frame_ready}, {39'd0, (m_cnt >= N)});
            check("cmp_load_err", {39'd0, load_err}, {39'd0, m_err});
            check("cmp_cfg_updated", {39'd0, cfg_updated}, {39'd0, m_upd});
        end
    end

    task automatic step(input logic r, input logic l, input logic s, input logic d);
        restore_defaults = r;
        load             = l;
        shift_en         = s;
        serial_data_in   = d;
        @(posedge serial_clock);
        #1;
    endtask

    task automatic shift_bits(input logic [39:0] w, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) step(1'b0, 1'b0, 1'b1, w[i]);
    endtask

    // Asserts reset between edges, checks the immediate effect, releases it.
    task automatic pulse_reset(input string tag);
        #2;
        resetn = 1'b0;
        #1;
        check({tag, "_gpio_async"}, gpio_config, DEF);
        check({tag, "_ready_async"}, {39'd0, frame_ready}, 40'd0);
        check({tag, "_sdo_async"}, {39'd0, serial_data_out}, 40'd0);
        @(negedge serial_clock);
        #2;
        resetn = 1'b1;
    endtask

    initial begin
        resetn           = 1'b1;
        shift_en         = 1'b0;
        serial_data_in   = 1'b0;
        load             = 1'b0;
        restore_defaults = 1'b0;
        #2;
        resetn = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(posedge serial_clock);
        @(negedge serial_clock);
        #2;
        resetn = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Full frame load, MSB first.
        shift_bits(40'hA55A3CC3F0, 39, 1);
        check("t2_ready_39", {39'd0, frame_ready}, 40'd0);
        shift_bits(40'hA55A3CC3F0, 0, 0);
        check("t2_ready_40", {39'd0, frame_ready}, 40'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("t2_gpio", gpio_config, 40'hA55A3CC3F0);
        check("t2_upd", {39'd0, cfg_updated}, 40'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("t2_upd_low", {39'd0, cfg_updated}, 40'd0);
        check("t2_ready_after", {39'd0, frame_ready}, 40'd0);

        // Reset asserted mid-clock with non-default configuration live.
        shift_bits(40'hFFFFFFFFFF, 7, 0);
        pulse_reset("t1");
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Short frame is rejected; one more bit completes it.
        shift_bits(40'h0F0F0F0F0F, 39, 1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("t3_err", {39'd0, load_err}, 40'd1);
        check("t3_gpio_kept", gpio_config, DEF);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("t3_err_low", {39'd0, load_err}, 40'd0);
        check("t3_ready_39", {39'd0, frame_ready}, 40'd0);
        shift_bits(40'h0F0F0F0F0F, 0, 0);
        check("t3_ready_40", {39'd0, frame_ready}, 40'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("t3_gpio", gpio_config, 40'h0F0F0F0F0F);

        // Load together with shift, then restore with everything asserted.
        shift_bits(40'h3333CCCC55, 39, 0);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        check("t4_gpio_preshift", gpio_config, 40'h3333CCCC55);
        check("t4_ready_cnt1", {39'd0, frame_ready}, 40'd0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("t4_gpio_restored", gpio_config, DEF);
        check("t4_no_err", {39'd0, load_err}, 40'd0);
        check("t4_upd", {39'd0, cfg_updated}, 40'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Overshift: five ones then a 40-bit word; defaults drain out first.
        pulse_reset("t5");
        step(1'b0, 1'b0, 1'b0, 1'b0);
        shift_bits(40'h000000001F, 4, 0);
        check("t5_sdo_after5", {39'd0, serial_data_out}, 40'd0);
        shift_bits(40'h123456789A, 39, 5);
        check("t5_sdo_after40", {39'd0, serial_data_out}, 40'd1);
        shift_bits(40'h123456789A, 4, 0);
        check("t5_ready_sat", {39'd0, frame_ready}, 40'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("t5_gpio", gpio_config, 40'h123456789A);

        // Reset mid-frame discards the partial frame.
        shift_bits(40'hFFFFF00000, 39, 20);
        pulse_reset("t6");
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("t6_err", {39'd0, load_err}, 40'd1);
        check("t6_gpio", gpio_config, DEF);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
